// File: rtl/sram_ser_driver_if.sv
// Host request/response and serial-SRAM pins of sram_ser_driver; master = driver side.
// SRAM_SER_RD_TIMEOUT_EN adds the rsp_err response flag.
interface sram_ser_driver_if #(
  parameter int COLS = 8,
  parameter int ROWS = 16
);
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [AW-1:0]   req_addr;
  logic [COLS-1:0] req_wdata;

  logic            serial_in;
  logic            shift;
  logic            load;
  logic            w_en;
  logic            r_en;
  logic [AW-1:0]   addr;
  logic            data_valid;
  logic [COLS-1:0] data_out;

  logic            rsp_valid;
  logic [COLS-1:0] rsp_data;
`ifdef SRAM_SER_RD_TIMEOUT_EN
  logic            rsp_err;
`endif

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, data_valid, data_out,
    output req_ready, serial_in, shift, load, w_en, r_en, addr, rsp_valid, rsp_data
`ifdef SRAM_SER_RD_TIMEOUT_EN
    , output rsp_err
`endif
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, data_valid, data_out,
    input  req_ready, serial_in, shift, load, w_en, r_en, addr, rsp_valid, rsp_data
`ifdef SRAM_SER_RD_TIMEOUT_EN
    , input rsp_err
`endif
  );
endinterface

// File: rtl/sram_ser_driver.sv
// Serial SRAM driver: write = COLS MSB-first shift cycles, load, w_en (ready again COLS+3 after accept); read holds r_en until data_valid.
// One request in flight, req_ready only in IDLE; SRAM_SER_RD_TIMEOUT_EN adds rsp_err and a 15-cycle read watchdog.
module sram_ser_driver #(
  parameter int COLS = 8,
  parameter int ROWS = 16
) (
  input logic               clk,
  input logic               arst,
  sram_ser_driver_if.master bus
);
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = $clog2(COLS + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    LOAD  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [COLS-1:0] sreg_q, sreg_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [COLS-1:0] rsp_data_q, rsp_data_d;
  logic            req_ready_q, req_ready_d;
  logic            serial_in_q, serial_in_d;
  logic            shift_q, shift_d;
  logic            load_q, load_d;
  logic            w_en_q, w_en_d;
  logic            r_en_q, r_en_d;
  logic            rsp_valid_q, rsp_valid_d;
`ifdef SRAM_SER_RD_TIMEOUT_EN
  logic [3:0]      wd_q, wd_d;
  logic            rsp_err_q, rsp_err_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sreg_d     = sreg_q;
    addr_d     = addr_q;
    rsp_data_d = rsp_data_q;
`ifdef SRAM_SER_RD_TIMEOUT_EN
    wd_d       = wd_q;
    rsp_err_d  = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          addr_d = bus.req_addr;
          if (bus.req_we) begin
            state_d = SHIFT;
            sreg_d  = bus.req_wdata;
            cnt_d   = CW'(1);
          end else begin
            state_d = READ;
`ifdef SRAM_SER_RD_TIMEOUT_EN
            wd_d    = 4'd1;
`endif
          end
        end
      end
      // cnt_q = bits already presented; the MSB of sreg_d is the next bit out
      SHIFT: begin
        if (cnt_q == CW'(COLS)) begin
          state_d = LOAD;
        end else begin
          sreg_d = sreg_q << 1;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      LOAD:  state_d = WRITE;
      WRITE: state_d = IDLE;
      READ: begin
        if (bus.data_valid) begin
          state_d    = RESP;
          rsp_data_d = bus.data_out;
`ifdef SRAM_SER_RD_TIMEOUT_EN
        end else if (wd_q == 4'd15) begin
          state_d   = RESP;
          rsp_err_d = 1'b1;
        end else begin
          wd_d = wd_q + 4'd1;
`endif
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pins are registered copies of the next state, so they line up with state_q.
    req_ready_d = (state_d == IDLE);
    shift_d     = (state_d == SHIFT);
    load_d      = (state_d == LOAD);
    w_en_d      = (state_d == WRITE);
    r_en_d      = (state_d == READ);
    rsp_valid_d = (state_d == RESP);
    serial_in_d = (state_d == SHIFT) ? sreg_d[COLS-1] : 1'b0;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sreg_q      <= '0;
      addr_q      <= '0;
      rsp_data_q  <= '0;
      req_ready_q <= 1'b1;
      serial_in_q <= 1'b0;
      shift_q     <= 1'b0;
      load_q      <= 1'b0;
      w_en_q      <= 1'b0;
      r_en_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef SRAM_SER_RD_TIMEOUT_EN
      wd_q        <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sreg_q      <= sreg_d;
      addr_q      <= addr_d;
      rsp_data_q  <= rsp_data_d;
      req_ready_q <= req_ready_d;
      serial_in_q <= serial_in_d;
      shift_q     <= shift_d;
      load_q      <= load_d;
      w_en_q      <= w_en_d;
      r_en_q      <= r_en_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef SRAM_SER_RD_TIMEOUT_EN
      wd_q        <= wd_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.serial_in = serial_in_q;
  assign bus.shift     = shift_q;
  assign bus.load      = load_q;
  assign bus.w_en      = w_en_q;
  assign bus.r_en      = r_en_q;
  assign bus.addr      = addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
`ifdef SRAM_SER_RD_TIMEOUT_EN
  assign bus.rsp_err   = rsp_err_q;
`endif
endmodule

// File: tb/tb_sram_ser_driver.sv
// Directed bench for sram_ser_driver (COLS=8, ROWS=16) with a small behavioural SIPO/SRAM model.
// Build with or without SRAM_SER_RD_TIMEOUT_EN.
module tb_sram_ser_driver;
  logic clk;
  logic arst;
  int   n_checks = 0;
  int   n_fail   = 0;

  sram_ser_driver_if #(.COLS(8), .ROWS(16)) bus ();

  sram_ser_driver #(.COLS(8), .ROWS(16)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  // SIPO register and array behind the driver pins
  logic [7:0] sipo;
  logic [7:0] word;
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (bus.shift) sipo <= {sipo[6:0], bus.serial_in};
    if (bus.load)  word <= sipo;
    if (bus.w_en)  mem[bus.addr] <= word;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // {req_ready, serial_in, shift, load, w_en, r_en, rsp_valid}
  function automatic logic [6:0] strobes();
    return {bus.req_ready, bus.serial_in, bus.shift, bus.load, bus.w_en, bus.r_en, bus.rsp_valid};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    #2;
    n_checks++;
    if (strobes() !== 7'b1000000) begin
      n_fail++; $display("FAIL reset_strobes got=%b exp=%b", strobes(), 7'b1000000);
    end
    n_checks++;
    if ({bus.addr, bus.rsp_data} !== 12'h000) begin
      n_fail++; $display("FAIL reset_addr_data got=%h exp=%h", {bus.addr, bus.rsp_data}, 12'h000);
    end
`ifdef SRAM_SER_RD_TIMEOUT_EN
    n_checks++;
    if (bus.rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp_err got=%b exp=0", bus.rsp_err);
    end
`endif
    step(); step();
    arst = 1'b0;
    step();
    n_checks++;
    if (strobes() !== 7'b1000000) begin
      n_fail++; $display("FAIL reset_release got=%b exp=%b", strobes(), 7'b1000000);
    end
  endtask

  task automatic test_write();
    logic [7:0] wd;
    wd = 8'hA5;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 4'd3; bus.req_wdata = wd;
    step();
    bus.req_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (strobes() !== {1'b0, wd[7-k], 5'b10000}) begin
        n_fail++; $display("FAIL write_shift%0d got=%b exp=%b", k, strobes(), {1'b0, wd[7-k], 5'b10000});
      end
      step();
    end
    n_checks++;
    if (strobes() !== 7'b0001000) begin
      n_fail++; $display("FAIL write_load got=%b exp=%b", strobes(), 7'b0001000);
    end
    step();
    n_checks++;
    if ({strobes(), bus.addr} !== {7'b0000100, 4'd3}) begin
      n_fail++; $display("FAIL write_wen got=%b/%0d exp=%b/3", strobes(), bus.addr, 7'b0000100);
    end
    step();
    n_checks++;
    if (strobes() !== 7'b1000000) begin
      n_fail++; $display("FAIL write_done got=%b exp=%b", strobes(), 7'b1000000);
    end
    n_checks++;
    if (mem[3] !== 8'hA5) begin
      n_fail++; $display("FAIL write_mem got=%h exp=a5", mem[3]);
    end
  endtask

  task automatic test_read_wait();
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 4'd3; bus.data_valid = 1'b0;
    step();
    bus.req_valid = 1'b0;
    n_checks++;
    if ({strobes(), bus.addr} !== {7'b0000010, 4'd3}) begin
      n_fail++; $display("FAIL read_ren1 got=%b/%0d exp=%b/3", strobes(), bus.addr, 7'b0000010);
    end
    step();
    n_checks++;
    if (strobes() !== 7'b0000010) begin
      n_fail++; $display("FAIL read_ren2 got=%b exp=%b", strobes(), 7'b0000010);
    end
    bus.data_valid = 1'b1; bus.data_out = mem[3];
    step();
    bus.data_valid = 1'b0; bus.data_out = 8'h00;
    n_checks++;
    if ({strobes(), bus.rsp_data} !== {7'b0000001, 8'hA5}) begin
      n_fail++; $display("FAIL read_rsp got=%b/%h exp=%b/a5", strobes(), bus.rsp_data, 7'b0000001);
    end
`ifdef SRAM_SER_RD_TIMEOUT_EN
    n_checks++;
    if (bus.rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL read_rsp_err got=%b exp=0", bus.rsp_err);
    end
`endif
    step();
    n_checks++;
    if ({strobes(), bus.rsp_data} !== {7'b1000000, 8'hA5}) begin
      n_fail++; $display("FAIL read_idle got=%b/%h exp=%b/a5", strobes(), bus.rsp_data, 7'b1000000);
    end
  endtask

  task automatic test_read_first();
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 4'd5;
    bus.data_valid = 1'b1; bus.data_out = 8'h3C;
    step();
    bus.req_valid = 1'b0;
    n_checks++;
    if ({strobes(), bus.rsp_data} !== {7'b0000010, 8'hA5}) begin
      n_fail++; $display("FAIL first_ren got=%b/%h exp=%b/a5", strobes(), bus.rsp_data, 7'b0000010);
    end
    step();
    bus.data_valid = 1'b0; bus.data_out = 8'h00;
    n_checks++;
    if ({strobes(), bus.rsp_data} !== {7'b0000001, 8'h3C}) begin
      n_fail++; $display("FAIL first_rsp got=%b/%h exp=%b/3c", strobes(), bus.rsp_data, 7'b0000001);
    end
    step();
    n_checks++;
    if (strobes() !== 7'b1000000) begin
      n_fail++; $display("FAIL first_idle got=%b exp=%b", strobes(), 7'b1000000);
    end
  endtask

  task automatic test_ignore_dv();
    bus.data_valid = 1'b1; bus.data_out = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({strobes(), bus.rsp_data} !== {7'b1000000, 8'h3C}) begin
        n_fail++; $display("FAIL ignore_dv%0d got=%b/%h exp=%b/3c", i, strobes(), bus.rsp_data, 7'b1000000);
      end
    end
    bus.data_valid = 1'b0; bus.data_out = 8'h00;
  endtask

`ifdef SRAM_SER_RD_TIMEOUT_EN
  task automatic test_read_timeout();
    int n_ren;
    n_ren = 0;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 4'd9; bus.data_valid = 1'b0;
    step();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 40 && bus.r_en === 1'b1; i++) begin
      n_ren++;
      step();
    end
    n_checks++;
    if (n_ren !== 15) begin
      n_fail++; $display("FAIL timeout_ren_cycles got=%0d exp=15", n_ren);
    end
    n_checks++;
    if ({strobes(), bus.rsp_err, bus.rsp_data} !== {7'b0000001, 1'b1, 8'h3C}) begin
      n_fail++; $display("FAIL timeout_rsp got=%b/%b/%h exp=%b/1/3c", strobes(), bus.rsp_err, bus.rsp_data, 7'b0000001);
    end
    step();
    n_checks++;
    if ({strobes(), bus.rsp_err} !== {7'b1000000, 1'b0}) begin
      n_fail++; $display("FAIL timeout_idle got=%b/%b exp=%b/0", strobes(), bus.rsp_err, 7'b1000000);
    end
  endtask
`else
  task automatic test_read_hold();
    int n_bad;
    n_bad = 0;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 4'd9; bus.data_valid = 1'b0;
    step();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (strobes() !== 7'b0000010) n_bad++;
      step();
    end
    n_checks++;
    if (n_bad !== 0) begin
      n_fail++; $display("FAIL hold_ren bad_cycles=%0d exp=0", n_bad);
    end
    bus.data_valid = 1'b1; bus.data_out = 8'h5A;
    step();
    bus.data_valid = 1'b0; bus.data_out = 8'h00;
    n_checks++;
    if ({strobes(), bus.rsp_data} !== {7'b0000001, 8'h5A}) begin
      n_fail++; $display("FAIL hold_rsp got=%b/%h exp=%b/5a", strobes(), bus.rsp_data, 7'b0000001);
    end
    step();
  endtask
`endif

  task automatic test_reset_mid();
    int n_bad;
    n_bad = 0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 4'd7; bus.req_wdata = 8'hC3;
    step();
    bus.req_valid = 1'b0;
    step(); step(); step();
    n_checks++;
    if (bus.shift !== 1'b1) begin
      n_fail++; $display("FAIL mid_shift4 got=%b exp=1", bus.shift);
    end
    #2;
    arst = 1'b1;
    #1;
    n_checks++;
    if ({strobes(), bus.addr, bus.rsp_data} !== {7'b1000000, 4'd0, 8'h00}) begin
      n_fail++; $display("FAIL mid_reset got=%b/%0d/%h exp=%b/0/00", strobes(), bus.addr, bus.rsp_data, 7'b1000000);
    end
    step(); step();
    arst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (strobes() !== 7'b1000000) n_bad++;
    end
    n_checks++;
    if (n_bad !== 0) begin
      n_fail++; $display("FAIL mid_no_strobes bad_cycles=%0d exp=0", n_bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] s;
    int acc, overlap, wen_ok, done;
    acc = -1; overlap = 0; wen_ok = 0; done = 0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 4'd0; bus.req_wdata = 8'h81;
    step();
    bus.req_addr = 4'd15; bus.req_wdata = 8'h7E;
    for (int c = 1; c <= 20; c++) begin
      s = strobes();
      if (int'(s[4]) + int'(s[3]) + int'(s[2]) + int'(s[1]) > 1) overlap++;
      if (c == 10 && bus.w_en === 1'b1 && bus.addr === 4'd0) wen_ok = 1;
      if (s[6] === 1'b1) begin
        acc = c;
        break;
      end
      step();
    end
    n_checks++;
    if (acc !== 11) begin
      n_fail++; $display("FAIL b2b_ready_cycle got=%0d exp=11", acc);
    end
    n_checks++;
    if (wen_ok !== 1) begin
      n_fail++; $display("FAIL b2b_first_wen got=%0d exp=1", wen_ok);
    end
    step();
    bus.req_valid = 1'b0;
    n_checks++;
    if ({bus.shift, bus.serial_in, bus.addr} !== {1'b1, 1'b0, 4'd15}) begin
      n_fail++; $display("FAIL b2b_second_start got=%b exp=%b", {bus.shift, bus.serial_in, bus.addr}, {1'b1, 1'b0, 4'd15});
    end
    for (int c = 0; c < 20; c++) begin
      s = strobes();
      if (int'(s[4]) + int'(s[3]) + int'(s[2]) + int'(s[1]) > 1) overlap++;
      if (s[6] === 1'b1) begin
        done = 1;
        break;
      end
      step();
    end
    n_checks++;
    if ({done, overlap} !== {32'd1, 32'd0}) begin
      n_fail++; $display("FAIL b2b_complete done=%0d overlap=%0d exp 1/0", done, overlap);
    end
    n_checks++;
    if ({mem[0], mem[15]} !== {8'h81, 8'h7E}) begin
      n_fail++; $display("FAIL b2b_mem got=%h/%h exp=81/7e", mem[0], mem[15]);
    end
  endtask

  initial begin
    clk = 1'b0; arst = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.data_valid = 1'b0; bus.data_out = '0;
    #1;
    test_reset();
    test_write();
    test_read_wait();
    test_read_first();
    test_ignore_dv();
`ifdef SRAM_SER_RD_TIMEOUT_EN
    test_read_timeout();
`else
    test_read_hold();
`endif
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
